// File: rtl/contingency_table_builder_pkg.sv
// Shared codes, table geometry and cell indexing for the contingency table builder.
package contingency_table_builder_pkg;
   localparam logic [1:0] GENO_AA   = 2'd0;
   localparam logic [1:0] GENO_AB   = 2'd1;
   localparam logic [1:0] GENO_BB   = 2'd2;
   localparam logic [1:0] GENO_MISS = 2'd3;

   localparam logic PHENO_CTRL = 1'b0;
   localparam logic PHENO_CASE = 1'b1;

   localparam int JOINT_CELLS  = 18;
   localparam int MARGIN_CELLS = 6;

   typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_REDUCE, ST_EMIT} state_t;

   function automatic int cell_index(input int a, input int b, input int c);
      return (a * 3 + b) * 2 + c;
   endfunction
endpackage

// File: rtl/contingency_table_builder_if.sv
// Sample stream in, packed tables out, plus the downstream busy flag.
interface contingency_table_builder_if
   import contingency_table_builder_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 4
);
   logic [2*LANES-1:0]                geno_a_in;
   logic [2*LANES-1:0]                geno_b_in;
   logic [LANES-1:0]                  pheno_in;
   logic [LANES-1:0]                  lane_mask_in;
   logic                              in_valid;
   logic                              in_last;
   logic                              in_ready;
   logic                              downstream_busy;
   logic [JOINT_CELLS*DATA_WIDTH-1:0]  joint_table_out;
   logic [MARGIN_CELLS*DATA_WIDTH-1:0] first_margin_out;
   logic [MARGIN_CELLS*DATA_WIDTH-1:0] second_margin_out;
   logic [2*DATA_WIDTH-1:0]           n_out;
   logic                              data_valid_out;

   modport master (
      output geno_a_in, geno_b_in, pheno_in, lane_mask_in, in_valid, in_last, downstream_busy,
      input  in_ready, joint_table_out, first_margin_out, second_margin_out, n_out, data_valid_out
   );
   modport slave (
      input  geno_a_in, geno_b_in, pheno_in, lane_mask_in, in_valid, in_last, downstream_busy,
      output in_ready, joint_table_out, first_margin_out, second_margin_out, n_out, data_valid_out
   );
endinterface

// File: rtl/ct_lane_decoder.sv
// Turns one input beat into per-cell increments: popcount of lanes landing in each joint cell.
module ct_lane_decoder
   import contingency_table_builder_pkg::*;
#(
   parameter int LANES = 4,
   parameter int INC_W = $clog2(LANES + 1)
) (
   input  logic [2*LANES-1:0]             geno_a,
   input  logic [2*LANES-1:0]             geno_b,
   input  logic [LANES-1:0]               pheno,
   input  logic [LANES-1:0]               lane_mask,
   output logic [JOINT_CELLS*INC_W-1:0]   inc
);
   always_comb begin
      inc = '0;
      for (int a = 0; a < 3; a++) begin
         for (int b = 0; b < 3; b++) begin
            for (int c = 0; c < 2; c++) begin
               for (int i = 0; i < LANES; i++) begin
                  // A missing code on either SNP drops the whole sample
                  if (lane_mask[i] &&
                      geno_a[2*i +: 2] != GENO_MISS && geno_b[2*i +: 2] != GENO_MISS &&
                      geno_a[2*i +: 2] == 2'(a) && geno_b[2*i +: 2] == 2'(b) &&
                      pheno[i] == 1'(c)) begin
                     inc[cell_index(a, b, c)*INC_W +: INC_W] =
                        inc[cell_index(a, b, c)*INC_W +: INC_W] + INC_W'(1);
                  end
               end
            end
         end
      end
   end
endmodule

// File: rtl/contingency_table_builder.sv
// Accumulates the 3x3x2 joint table for one SNP pair, reduces margins and counts,
// then emits everything as one packed beat gated by downstream busy.
module contingency_table_builder
   import contingency_table_builder_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   contingency_table_builder_if.slave bus
);
   localparam int INC_W = $clog2(LANES + 1);
   localparam int ACC_W = DATA_WIDTH + $clog2(LANES) + 1;
   localparam int SUM_W = DATA_WIDTH + 4;
   localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;

   function automatic logic [DATA_WIDTH-1:0] sat_acc(input logic [ACC_W-1:0] v);
      return (v > ACC_W'(CNT_MAX)) ? CNT_MAX : v[DATA_WIDTH-1:0];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] sat_sum(input logic [SUM_W-1:0] v);
      return (v > SUM_W'(CNT_MAX)) ? CNT_MAX : v[DATA_WIDTH-1:0];
   endfunction

   state_t                              state;
   logic                                ready_q;
   logic [DATA_WIDTH-1:0]               cnt [JOINT_CELLS];
   logic [JOINT_CELLS*INC_W-1:0]        inc;
   logic [SUM_W-1:0]                    sum_first  [MARGIN_CELLS];
   logic [SUM_W-1:0]                    sum_second [MARGIN_CELLS];
   logic [SUM_W-1:0]                    sum_n      [2];
   logic [JOINT_CELLS*DATA_WIDTH-1:0]   joint_q;
   logic [MARGIN_CELLS*DATA_WIDTH-1:0]  first_q;
   logic [MARGIN_CELLS*DATA_WIDTH-1:0]  second_q;
   logic [2*DATA_WIDTH-1:0]             n_q;
   logic                                accept;
   logic                                fire;

   ct_lane_decoder #(.LANES(LANES), .INC_W(INC_W)) u_dec (
      .geno_a    (bus.geno_a_in),
      .geno_b    (bus.geno_b_in),
      .pheno     (bus.pheno_in),
      .lane_mask (bus.lane_mask_in),
      .inc       (inc)
   );

   assign accept = bus.in_valid && ready_q;
   // The pulse follows busy combinationally so a falling busy fires in the same cycle
   assign fire   = (state == ST_EMIT) && !bus.downstream_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < JOINT_CELLS; k++) cnt[k] <= '0;
      end else if (fire) begin
         for (int k = 0; k < JOINT_CELLS; k++) cnt[k] <= '0;
      end else if (accept) begin
         for (int k = 0; k < JOINT_CELLS; k++)
            cnt[k] <= sat_acc(ACC_W'(cnt[k]) + ACC_W'(inc[k*INC_W +: INC_W]));
      end
   end

   always_comb begin
      for (int m = 0; m < MARGIN_CELLS; m++) begin
         sum_first[m]  = '0;
         sum_second[m] = '0;
      end
      sum_n[0] = '0;
      sum_n[1] = '0;
      for (int a = 0; a < 3; a++) begin
         for (int b = 0; b < 3; b++) begin
            for (int c = 0; c < 2; c++) begin
               sum_first[a*2+c]  = sum_first[a*2+c]  + SUM_W'(cnt[cell_index(a, b, c)]);
               sum_second[b*2+c] = sum_second[b*2+c] + SUM_W'(cnt[cell_index(a, b, c)]);
               sum_n[c]          = sum_n[c]          + SUM_W'(cnt[cell_index(a, b, c)]);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         ready_q  <= 1'b0;
         joint_q  <= '0;
         first_q  <= '0;
         second_q <= '0;
         n_q      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               ready_q <= 1'b1;
               if (accept) begin
                  if (bus.in_last) begin
                     state   <= ST_REDUCE;
                     ready_q <= 1'b0;
                  end else begin
                     state <= ST_ACCUM;
                  end
               end
            end
            ST_ACCUM: begin
               if (accept && bus.in_last) begin
                  state   <= ST_REDUCE;
                  ready_q <= 1'b0;
               end
            end
            ST_REDUCE: begin
               for (int k = 0; k < JOINT_CELLS; k++)
                  joint_q[k*DATA_WIDTH +: DATA_WIDTH] <= cnt[k];
               for (int m = 0; m < MARGIN_CELLS; m++) begin
                  first_q[m*DATA_WIDTH +: DATA_WIDTH]  <= sat_sum(sum_first[m]);
                  second_q[m*DATA_WIDTH +: DATA_WIDTH] <= sat_sum(sum_second[m]);
               end
               n_q   <= {sat_sum(sum_n[1]), sat_sum(sum_n[0])};
               state <= ST_EMIT;
            end
            ST_EMIT: begin
               if (!bus.downstream_busy) begin
                  state   <= ST_IDLE;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state   <= ST_IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready          = ready_q;
   assign bus.joint_table_out   = joint_q;
   assign bus.first_margin_out  = first_q;
   assign bus.second_margin_out = second_q;
   assign bus.n_out             = n_q;
   assign bus.data_valid_out    = fire;
endmodule

// File: doc/contingency_table_builder.md
Name: contingency_table_builder

Overview:
- Upstream of the P calculation stage: consumes a streamed, genotype-encoded sample set for one SNP pair and builds the 3x3x2 joint contingency table, both 3x2 marginal tables and the per-class sample counts.
- Emits all tables as one packed beat with a single-cycle valid pulse.
- Holds the pulse off while the downstream stage reports busy.

Parameters:
- DATA_WIDTH, 16, width of every count cell; counts saturate at 2^DATA_WIDTH-1.
- LANES, 4, samples carried per input beat.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- geno_a_in  in  2*LANES  SNP A genotype per lane; lane i at bits [2i+1:2i]; codes 0/1/2 are valid, 3 means missing.
- geno_b_in  in  2*LANES  SNP B genotype per lane, same packing.
- pheno_in  in  LANES  class per lane: 0 = control, 1 = case.
- lane_mask_in  in  LANES  1 = lane holds a sample.
- in_valid  in  1  beat valid.
- in_last  in  1  final beat of this SNP pair.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- downstream_busy  in  1  busy flag from the P calculation stage.
- joint_table_out  out  18*DATA_WIDTH  cell index (a*3+b)*2+c, cell 0 at LSBs.
- first_margin_out  out  6*DATA_WIDTH  SNP A margin; index a*2+c.
- second_margin_out  out  6*DATA_WIDTH  SNP B margin; index b*2+c.
- n_out  out  2*DATA_WIDTH  [DW-1:0] = control count, [2DW-1:DW] = case count.
- data_valid_out  out  1  one-cycle pulse; all table outputs are valid in that cycle.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - State goes to IDLE.
  - All 18 counters, all output registers and data_valid_out go to 0.
  - in_ready goes to 0 during reset, then 1 in IDLE.
- States: IDLE, ACCUM, REDUCE, EMIT.
  - IDLE: in_ready=1. An accepted beat updates the counters. Go to REDUCE if in_last, else to ACCUM.
  - ACCUM: in_ready=1. Each accepted beat updates the counters. The in_last beat moves to REDUCE.
  - REDUCE: in_ready=0. In one cycle, register the joint table and compute and register both margins and n from the counters (sum over b, sum over a, sum over all 9 genotype cells per class). Next state is EMIT.
  - EMIT: in_ready=0. If !downstream_busy:
    - assert data_valid_out for exactly one cycle;
    - clear the counters;
    - go to IDLE.
    - If downstream_busy, hold with data_valid_out=0 and outputs stable.
- Counting per accepted beat, per lane i with lane_mask_in[i]=1:
  - If either genotype is 3, the sample is skipped.
  - Otherwise increment cell (a*3+b)*2+pheno.
  - Up to LANES increments can hit the same cell in one beat; the per-cell increment is the popcount of matching lanes.
- Arithmetic:
  - Counter update uses DATA_WIDTH+log2(LANES)+1 bit intermediates and saturates to 2^DATA_WIDTH-1.
  - Margin and n sums use DATA_WIDTH+4 bit intermediates and saturate likewise.
- Latency: in_last accepted at cycle T, then REDUCE at T+1, then data_valid_out at T+2 when downstream_busy=0 at T+2.
- Output registers hold their values after the pulse until the next REDUCE.
- Boundary cases:
  - A beat with in_valid=1 and lane_mask_in=0 is accepted and counts nothing. If in_last is set, the table is emitted anyway (possibly all zero).
  - An all-missing pair emits all zeros with a valid pulse.
  - in_valid=0 in ACCUM: hold; no timeout.
  - in_valid is ignored whenever in_ready=0.
  - downstream_busy falling in EMIT: the pulse fires in that same cycle.
  - rst_n asserted mid-operation: partial counts are discarded and no pulse is produced.

Decomposition:
- Shared package holds:
  - genotype codes GENO_AA=0, GENO_AB=1, GENO_BB=2, GENO_MISS=3;
  - PHENO_CTRL=0, PHENO_CASE=1;
  - JOINT_CELLS=18, MARGIN_CELLS=6;
  - the cell-index function (a*3+b)*2+c.
- Sub-module ct_lane_decoder (combinational): takes one beat and returns an 18-entry vector of per-cell increments (0..LANES).

Test Plan:
- Single beat with in_last, LANES=4, samples (a,b,c) = (0,0,0),(1,2,1),(2,1,0),(0,0,0) -> at T+2:
  - joint cell0=2, cell11=1, cell14=1;
  - first margin [0]=2, [3]=1, [4]=1;
  - second margin [0]=2, [2]=1, [5]=1;
  - n = {case 1, control 3}.
- 3 beats with mixed lane_mask 4'b1111, 4'b0101, 4'b0001, all samples (1,1,1) -> cell9=7, first margin [3]=7, second margin [3]=7, n case=7, one pulse only.
- Missing codes: a beat with geno_a lanes {3,0,3,0}, geno_b all 0, pheno 0 -> cell0=2 and n control=2.
- downstream_busy held high for 5 cycles after REDUCE -> no pulse and outputs stable; the pulse fires in the cycle busy drops; in_ready=0 throughout.
- Saturation with DATA_WIDTH=4: 5 beats of 4 lanes all (2,2,1) -> cell17=15, margins 15, n case=15, no wrap.
- rst_n pulsed low during ACCUM after 2 beats -> no pulse; the next pair counts from zero.
